// File: rtl/exp3_fluxo_dados_desafio_pkg.sv
// Shared widths and reference ROM contents for the experiment-3 challenge datapath.
package exp3_fluxo_dados_desafio_pkg;

    localparam int N = 4;  // data width: switches, register, ROM word
    localparam int M = 4;  // address width; ROM depth is 2**M

    localparam int ROM_DEPTH = 1 << M;

    // Reference sequence the player must reproduce, address 0 first.
    localparam logic [N-1:0] ROM_INIT [0:ROM_DEPTH-1] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0100, 4'b0010, 4'b0001, 4'b0001,
        4'b0010, 4'b0010, 4'b0100, 4'b0100,
        4'b1000, 4'b1000, 4'b0001, 4'b0100
    };

endpackage

// File: rtl/exp3_fluxo_dados_desafio_if.sv
// Command/status bundle between the control unit (master) and the datapath (slave).
interface exp3_fluxo_dados_desafio_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic         zeraC;
    logic         contaC;
    logic         zeraR;
    logic         registraR;
    logic [N-1:0] chaves;
    logic         fimC;
    logic         fimDiferente;
    logic         igual;
    logic [M-1:0] db_contagem;
    logic [N-1:0] db_memoria;
    logic [N-1:0] db_chaves;

    modport master (
        output zeraC, contaC, zeraR, registraR, chaves,
        input  fimC, fimDiferente, igual, db_contagem, db_memoria, db_chaves
    );

    modport slave (
        input  zeraC, contaC, zeraR, registraR, chaves,
        output fimC, fimDiferente, igual, db_contagem, db_memoria, db_chaves
    );
endinterface

// File: rtl/exp3_fluxo_dados_desafio_rom.sv
// Fixed 16x4 reference ROM, purely combinational read.
module exp3_fluxo_dados_desafio_rom
    import exp3_fluxo_dados_desafio_pkg::*;
(
    input  logic [M-1:0] addr,
    output logic [N-1:0] data
);

    // Case-statement lookup so synthesis maps it to plain logic.
    always_comb begin
        data = '0;
        case (addr)
            4'h0: data = ROM_INIT[0];
            4'h1: data = ROM_INIT[1];
            4'h2: data = ROM_INIT[2];
            4'h3: data = ROM_INIT[3];
            4'h4: data = ROM_INIT[4];
            4'h5: data = ROM_INIT[5];
            4'h6: data = ROM_INIT[6];
            4'h7: data = ROM_INIT[7];
            4'h8: data = ROM_INIT[8];
            4'h9: data = ROM_INIT[9];
            4'hA: data = ROM_INIT[10];
            4'hB: data = ROM_INIT[11];
            4'hC: data = ROM_INIT[12];
            4'hD: data = ROM_INIT[13];
            4'hE: data = ROM_INIT[14];
            4'hF: data = ROM_INIT[15];
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/exp3_fluxo_dados_desafio.sv
// Experiment-3 challenge datapath: address counter, reference ROM,
// switch-capture register and equality comparator.
module exp3_fluxo_dados_desafio
    import exp3_fluxo_dados_desafio_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    exp3_fluxo_dados_desafio_if.slave bus
);

    logic [M-1:0] contagem;
    logic [N-1:0] registro;
    logic [N-1:0] memoria;
    logic         iguais;

    // Address counter: reset, then clear, then increment (wraps naturally at 2**M-1).
    always_ff @(posedge clock) begin
        if (!reset)
            contagem <= '0;
        else if (bus.zeraC)
            contagem <= '0;
        else if (bus.contaC)
            contagem <= contagem + 1'b1;
    end

    // Switch-capture register, independent of the counter commands.
    always_ff @(posedge clock) begin
        if (!reset)
            registro <= '0;
        else if (bus.zeraR)
            registro <= '0;
        else if (bus.registraR)
            registro <= bus.chaves;
    end

    exp3_fluxo_dados_desafio_rom u_rom (
        .addr (contagem),
        .data (memoria)
    );

    // Status is taken from state only, so the controller sees a settled result.
    always_comb begin
        iguais = (registro == memoria);
    end

    assign bus.igual        = iguais;
    assign bus.fimDiferente = ~iguais;
    assign bus.fimC         = (contagem == {M{1'b1}});
    assign bus.db_contagem  = contagem;
    assign bus.db_memoria   = memoria;
    assign bus.db_chaves    = registro;

endmodule

// File: tb/tb_exp3_fluxo_dados_desafio.sv
// Self-checking bench for the experiment-3 challenge datapath.
module tb_exp3_fluxo_dados_desafio;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    exp3_fluxo_dados_desafio_if #(.N(4), .M(4)) bus ();

    exp3_fluxo_dados_desafio dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent copy of the reference sequence.
    logic [3:0] rom_tab [16];
    int         m_cnt;
    logic [3:0] m_reg;
    bit         m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive commands, take the edge, advance the model, settle.
    task automatic step(input logic rst, input logic zc, input logic cc,
                        input logic zr, input logic rr, input logic [3:0] ch);
        reset         = rst;
        bus.zeraC     = zc;
        bus.contaC    = cc;
        bus.zeraR     = zr;
        bus.registraR = rr;
        bus.chaves    = ch;
        @(posedge clock);
        if (!rst) begin
            m_cnt   = 0;
            m_reg   = 4'h0;
            m_valid = 1'b1;
        end else begin
            if (zc)      m_cnt = 0;
            else if (cc) m_cnt = (m_cnt + 1) % 16;
            if (zr)      m_reg = 4'h0;
            else if (rr) m_reg = ch;
        end
        #1;
    endtask

    // Every cycle, away from the edge, all outputs against the model.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("db_contagem",  bus.db_contagem,  m_cnt[3:0]);
            chk("db_chaves",    bus.db_chaves,    m_reg);
            chk("db_memoria",   bus.db_memoria,   rom_tab[m_cnt]);
            chk("igual",        bus.igual,        m_reg == rom_tab[m_cnt]);
            chk("fimDiferente", bus.fimDiferente, m_reg != rom_tab[m_cnt]);
            chk("fimC",         bus.fimC,         m_cnt == 15);
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        m_valid = 1'b0;
        m_cnt   = 0;
        m_reg   = 4'h0;
        rom_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                    4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

        // Reset held for two edges with noise on the command lines.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("rst_contagem", bus.db_contagem, 4'h0);
        chk("rst_chaves",   bus.db_chaves,   4'h0);
        chk("rst_memoria",  bus.db_memoria,  4'b0001);
        chk("rst_fimDif",   bus.fimDiferente, 1'b1);
        chk("rst_igual",    bus.igual,       1'b0);
        chk("rst_fimC",     bus.fimC,        1'b0);

        // Correct sweep through all 16 addresses.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rom_tab[i]);
            chk("sweep_igual", bus.igual, 1'b1);
            chk("sweep_fimC",  bus.fimC,  (i == 15) ? 1'b1 : 1'b0);
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        end
        chk("wrap_contagem", bus.db_contagem, 4'h0);
        chk("wrap_fimC",     bus.fimC,        1'b0);

        // Mismatch at address 3.
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
        chk("mis_igual",   bus.igual,        1'b0);
        chk("mis_fimDif",  bus.fimDiferente, 1'b1);
        chk("mis_chaves",  bus.db_chaves,    4'b0100);
        chk("mis_memoria", bus.db_memoria,   4'b1000);

        // Clear beats count / load.
        repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("pri_at5", bus.db_contagem, 4'h5);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("pri_zeraC", bus.db_contagem, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
        chk("pri_zeraR", bus.db_chaves, 4'h0);

        // Mid-run reset, including a check that nothing moves before the edge.
        repeat (9) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
        chk("mid_pre_cnt", bus.db_contagem, 4'h9);
        chk("mid_pre_reg", bus.db_chaves,   4'b0010);
        reset         = 1'b0;
        bus.contaC    = 1'b1;
        bus.registraR = 1'b1;
        bus.chaves    = 4'h7;
        #2;
        chk("mid_async_cnt", bus.db_contagem, 4'h9);
        chk("mid_async_reg", bus.db_chaves,   4'b0010);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7);
        chk("mid_cnt", bus.db_contagem, 4'h0);
        chk("mid_reg", bus.db_chaves,   4'h0);

        // Hold with toggling switches.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h8);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
            chk("hold_cnt", bus.db_contagem, 4'h1);
            chk("hold_reg", bus.db_chaves,   4'h8);
        end

        // Random commands; the per-cycle compare does the checking.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0) ? rom_tab[m_cnt] : 4'($urandom_range(0, 15)));
        end

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp3_fluxo_dados_desafio.md
# exp3_fluxo_dados_desafio

Datapath for the experiment-3 challenge circuit. It holds the 4-bit address counter, the fixed 16x4 reference ROM, the switch-capture register and the equality comparator. It executes the control unit's zeraC/contaC/zeraR/registraR commands and returns the fimC (last address) and fimDiferente (mismatch) status signals that unit consumes.

## Interface
Parameters:
- N, 4, data width (switches, register, ROM word)
- M, 4, address width; ROM depth 2^M

Ports:
- clock  in  1  rising-edge clock, sole clock
- reset  in  1  synchronous, active-low; clears counter and register
- zeraC  in  1  synchronous counter clear
- contaC  in  1  counter increment enable
- zeraR  in  1  synchronous register clear
- registraR  in  1  register load enable
- chaves  in  N  switch inputs
- fimC  out  1  high when counter == 2^M-1
- fimDiferente  out  1  high when registered switches != ROM word
- igual  out  1  high when registered switches == ROM word
- db_contagem  out  M  current counter value
- db_memoria  out  N  ROM word at current address
- db_chaves  out  N  current register contents

## Operation
- Counter priority: reset low > zeraC > contaC > hold. contaC at 2^M-1 wraps to 0.
- Register priority: reset low > zeraR > registraR (loads chaves) > hold.
- ROM: combinational read, address = counter. Contents, addresses 0..F: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- igual = (register == ROM word); fimDiferente = ~igual. Both are combinational from state, not registered.
- fimC = (counter == 2^M-1), combinational.
- zeraC with contaC both high: clear wins. zeraR with registraR both high: clear wins.
- The counter and register are independent. The same edge may clear or count one and load the other.
- fimDiferente is meaningful only in the controller's comparison state. At other times it is a don't-care to the controller, but it must still be driven (never X).

## Timing
- Reset values, after one edge with reset=0: db_contagem=0, db_chaves=0, db_memoria=0001, fimC=0, igual=0, fimDiferente=1.
- reset asserted mid-operation: both state elements are 0 after the next edge, regardless of other commands.
- registraR high at edge k: db_chaves valid after edge k. igual and fimDiferente are valid in the same cycle, so the controller's comparison state (one cycle after registra) sees a settled result.
- contaC high at edge k: new address after edge k. db_memoria, fimC and the comparator reflect the new address combinationally in that cycle.
- Zero-cycle combinational path from state to all status outputs. No input-to-output combinational path except through the state elements.

## Structure
- A shared package or header holds N, M and the ROM init constants, so the bench can read expected values from the same source.
- Natural sub-modules:
  - rom_16x4: combinational case-statement ROM.
  - Counter inline, or as contador_m with zera/conta/fim ports.
- Register and comparator are written inline.
- Top-level wiring with the control unit lives in a separate circuit module, not here.

## Test plan
- Reset check: hold reset=0 for 2 edges, then release -> db_contagem=0, db_chaves=0, db_memoria=0001, fimDiferente=1, fimC=0.
- Full correct sweep: for i=0..15, registraR with chaves=ROM[i], then contaC -> igual=1 at every address. fimC=1 only at address F. The contaC at F wraps db_contagem to 0 and fimC to 0.
- Mismatch: at address 3, registraR with chaves=0100 -> igual=0, fimDiferente=1, db_chaves=0100, db_memoria=1000.
- Priority: zeraC=contaC=1 at count 5 -> count 0. zeraR=registraR=1 with chaves=1111 -> db_chaves=0.
- Mid-run reset: advance to count 9 with db_chaves=0010, then pulse reset=0 with contaC=registraR=1 -> count 0 and register 0 after that edge. No asynchronous change before the edge.
- Hold: all commands low for 5 cycles with chaves toggling -> db_contagem and db_chaves unchanged.
